// File: rtl/jtag_master.sv
// jtag_master: command-driven JTAG sequencer.
//
// A command (TAP reset, IR scan, DR scan or idle clocks) is taken on a
// cmd_valid/cmd_ready handshake. The engine then produces the matching
// TCK/TMS/TDI bit stream. Each TCK bit is CLK_DIV sys_clk cycles low
// followed by CLK_DIV cycles high. It ends with a one-cycle rsp_valid
// pulse that carries the TDO bits captured during the shift bits.
//
// Ports
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   cmd_valid / cmd_ready   command handshake
//   cmd_op                  00 TAP reset, 01 IR scan, 10 DR scan, 11 idle
//   cmd_len                 shift/idle length; 0 is treated as 1, >32 as 32
//   cmd_data                TDI bits, shifted LSB first
//   rsp_valid, rsp_data     completion pulse and captured TDO bits
//   jtag_tck/tms/tdi/tdo    JTAG pins
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high
// S_HDR   | TMS walk from Run-Test/Idle to Shift-IR/DR
// S_SHIFT | shift bits (scan ops), or the whole bit sequence (reset/idle)
// S_TRL   | Exit1 -> Update -> Run-Test/Idle
// S_DONE  | one cycle: rsp_valid, and a new command may be accepted
module jtag_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        jtag_tck,
    output logic        jtag_tms,
    output logic        jtag_tdi,
    input  logic        jtag_tdo
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_TRL   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] OP_RST  = 2'b00;
    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_IDLE = 2'b11;

    localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);

    logic [2:0]  state;
    logic [1:0]  op_q;
    logic [4:0]  len_m1;
    logic [4:0]  bit_cnt;     // bits left in the current segment after this one
    logic [7:0]  phase;
    logic        tail;        // trailing low period after the last TCK bit
    logic [31:0] data_sr;
    logic [31:0] cap;

    logic [4:0]  cmd_len_m1;
    logic [2:0]  start_state;
    logic [4:0]  start_cnt;
    logic [2:0]  seg_state;
    logic [4:0]  seg_cnt;
    logic        seg_end;
    logic        scan_q;
    logic [4:0]  cap_idx;

    // TMS value of a bit, given the segment and the count of bits left after it.
    function automatic logic tms_for(input logic [2:0] st, input logic [1:0] op,
                                     input logic [4:0] cnt);
        logic t;
        t = 1'b0;
        case (st)
            S_HDR:   t = (op == OP_IR) ? (cnt >= 5'd2) : (cnt == 5'd2);
            S_SHIFT: begin
                if (op == OP_RST)       t = (cnt != 5'd0);
                else if (op == OP_IDLE) t = 1'b0;
                else                    t = (cnt == 5'd0);
            end
            S_TRL:   t = (cnt == 5'd1);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    assign scan_q  = op_q[0] ^ op_q[1];
    assign cap_idx = len_m1 - bit_cnt;

    always_comb begin
        cmd_len_m1 = 5'd0;
        if (cmd_len == 6'd0)
            cmd_len_m1 = 5'd0;
        else if (cmd_len >= 6'd32)
            cmd_len_m1 = 5'd31;
        else
            cmd_len_m1 = 5'(cmd_len - 6'd1);

        start_state = S_SHIFT;
        start_cnt   = cmd_len_m1;
        if (cmd_op == OP_RST) begin
            start_cnt = 5'd5;
        end else if (cmd_op != OP_IDLE) begin
            start_state = S_HDR;
            start_cnt   = (cmd_op == OP_IR) ? 5'd3 : 5'd2;
        end
    end

    // Where the next TCK bit belongs once the current one finishes.
    always_comb begin
        seg_state = state;
        seg_cnt   = bit_cnt - 5'd1;
        seg_end   = 1'b0;
        if (bit_cnt == 5'd0) begin
            case (state)
                S_HDR: begin
                    seg_state = S_SHIFT;
                    seg_cnt   = len_m1;
                end
                S_SHIFT: begin
                    if (scan_q) begin
                        seg_state = S_TRL;
                        seg_cnt   = 5'd1;
                    end else begin
                        seg_end = 1'b1;
                    end
                end
                default: seg_end = 1'b1;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            op_q      <= 2'b00;
            len_m1    <= 5'd0;
            bit_cnt   <= 5'd0;
            phase     <= 8'd0;
            tail      <= 1'b0;
            data_sr   <= '0;
            cap       <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            jtag_tck  <= 1'b0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (cmd_valid) begin
                        state     <= start_state;
                        bit_cnt   <= start_cnt;
                        op_q      <= cmd_op;
                        len_m1    <= cmd_len_m1;
                        data_sr   <= cmd_data;
                        cap       <= '0;
                        phase     <= 8'd0;
                        tail      <= 1'b0;
                        cmd_ready <= 1'b0;
                        jtag_tck  <= 1'b0;
                        // The first bit is never a shift bit, so TDI starts at 0.
                        jtag_tms  <= tms_for(start_state, cmd_op, start_cnt);
                        jtag_tdi  <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    if (phase != PH_LAST) begin
                        phase <= phase + 8'd1;
                    end else begin
                        phase <= 8'd0;
                        if (tail) begin
                            state     <= S_DONE;
                            tail      <= 1'b0;
                            rsp_valid <= 1'b1;
                            cmd_ready <= 1'b1;
                            rsp_data  <= cap;
                        end else if (!jtag_tck) begin
                            jtag_tck <= 1'b1;
                        end else begin
                            // Last cycle of the high phase: sample, then fall.
                            jtag_tck <= 1'b0;
                            if (state == S_SHIFT && scan_q)
                                cap[cap_idx] <= jtag_tdo;
                            if (seg_end) begin
                                tail     <= 1'b1;
                                jtag_tms <= 1'b0;
                                jtag_tdi <= 1'b0;
                            end else begin
                                state    <= seg_state;
                                bit_cnt  <= seg_cnt;
                                jtag_tms <= tms_for(seg_state, op_q, seg_cnt);
                                if (seg_state == S_SHIFT && scan_q) begin
                                    jtag_tdi <= data_sr[0];
                                    data_sr  <= data_sr >> 1;
                                end else begin
                                    jtag_tdi <= 1'b0;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: directed bench for jtag_master with CLK_DIV=2.
// An expected-cycle queue is built from the JTAG op rules for each accepted
// command. One compare process checks every cycle against it, and against
// idle expectations when no command is in flight.
module tb_jtag_master;

    localparam int HALF = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;

    logic        tdo_loop = 1'b0;
    logic        tdo_const = 1'b0;
    assign jtag_tdo = tdo_loop ? jtag_tdi : tdo_const;

    jtag_master #(.CLK_DIV(HALF)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .jtag_tck (jtag_tck),
        .jtag_tms (jtag_tms),
        .jtag_tdi (jtag_tdi),
        .jtag_tdo (jtag_tdo)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic        tck;
        logic        tms;
        logic        tdi;
        logic        ready;
        logic        valid;
        logic [31:0] rsp;
    } cyc_t;

    cyc_t        exp_q[$];
    cyc_t        cur;
    int          total = 0;
    int          bad = 0;
    logic        chk_en = 1'b0;
    logic        idle_tms = 1'b1;
    logic [31:0] last_rsp = 32'h0;
    int          tck_rises = 0;
    int          valid_pulses = 0;
    logic [63:0] tms_log = 64'h0;
    logic        prev_tck = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected pin activity for one command, from the TAP walk rules.
    task automatic push_cmd(input logic [1:0] op, input logic [5:0] len,
                            input logic [31:0] data, input logic [1:0] mode);
        int          n;
        logic        tq[$];
        logic        dq[$];
        logic [31:0] rsp;
        cyc_t        e;
        n   = (len == 6'd0) ? 1 : (len > 6'd32) ? 32 : int'(len);
        rsp = 32'h0;
        if (op == 2'b00) begin
            for (int i = 0; i < 6; i++) begin
                tq.push_back(i < 5);
                dq.push_back(1'b0);
            end
        end else if (op == 2'b11) begin
            for (int i = 0; i < n; i++) begin
                tq.push_back(1'b0);
                dq.push_back(1'b0);
            end
        end else begin
            tq.push_back(1'b1);
            if (op == 2'b01) tq.push_back(1'b1);
            tq.push_back(1'b0);
            tq.push_back(1'b0);
            while (dq.size() < tq.size()) dq.push_back(1'b0);
            for (int i = 0; i < n; i++) begin
                tq.push_back(i == n - 1);
                dq.push_back(data[i]);
                rsp[i] = (mode == 2'd2) ? data[i] : mode[0];
            end
            tq.push_back(1'b1);
            tq.push_back(1'b0);
            dq.push_back(1'b0);
            dq.push_back(1'b0);
        end
        for (int k = 0; k < tq.size(); k++) begin
            for (int h = 0; h < 2 * HALF; h++) begin
                e.tck = (h >= HALF);
                e.tms = tq[k];
                e.tdi = dq[k];
                e.ready = 1'b0;
                e.valid = 1'b0;
                e.rsp = 32'h0;
                exp_q.push_back(e);
            end
        end
        for (int h = 0; h < HALF; h++) begin
            e = '{tck: 1'b0, tms: 1'b0, tdi: 1'b0, ready: 1'b0, valid: 1'b0, rsp: 32'h0};
            exp_q.push_back(e);
        end
        e = '{tck: 1'b0, tms: 1'b0, tdi: 1'b0, ready: 1'b1, valid: 1'b1, rsp: rsp};
        exp_q.push_back(e);
        idle_tms = 1'b0;
    endtask

    always @(negedge sys_clk) begin
        if (chk_en) begin
            if (jtag_tck && !prev_tck) begin
                tck_rises++;
                tms_log = {tms_log[62:0], jtag_tms};
            end
            prev_tck = jtag_tck;
            if (rsp_valid) valid_pulses++;
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                check("tck", jtag_tck, cur.tck);
                check("tms", jtag_tms, cur.tms);
                check("tdi", jtag_tdi, cur.tdi);
                check("cmd_ready", cmd_ready, cur.ready);
                check("rsp_valid", rsp_valid, cur.valid);
                if (cur.valid) begin
                    check("rsp_data", rsp_data, cur.rsp);
                    last_rsp = cur.rsp;
                end else begin
                    check("rsp_hold", rsp_data, last_rsp);
                end
            end else begin
                check("idle_tck", jtag_tck, 1'b0);
                check("idle_tms", jtag_tms, idle_tms);
                check("idle_tdi", jtag_tdi, 1'b0);
                check("idle_ready", cmd_ready, 1'b1);
                check("idle_valid", rsp_valid, 1'b0);
                check("idle_rsp_hold", rsp_data, last_rsp);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] len,
                         input logic [31:0] data, input logic [1:0] mode);
        @(negedge sys_clk);
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        tdo_loop  = (mode == 2'd2);
        tdo_const = mode[0];
        cmd_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        push_cmd(op, len, data, mode);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!rsp_valid && n < 1000);
        if (!rsp_valid) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic settle();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int r0;
        int p0;

        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_tck", jtag_tck, 1'b0);
        check("rst_tms", jtag_tms, 1'b1);
        check("rst_tdi", jtag_tdi, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_rsp", rsp_data, 32'h0);
        sys_rst = 1'b0;
        chk_en  = 1'b1;
        repeat (2) @(posedge sys_clk);

        // TAP reset
        r0 = tck_rises;
        issue(2'b00, 6'd6, 32'hFFFF_FFFF, 2'd1);
        wait_rsp("s1");
        settle();
        check("s1_rsp", rsp_data, 32'h0);
        check("s1_rises", 64'(tck_rises - r0), 64'd6);
        check("s1_tms_seq", tms_log[5:0], 6'b111110);

        // DR 32, loopback
        r0 = tck_rises;
        issue(2'b10, 6'd32, 32'hDEAD_BEEF, 2'd2);
        wait_rsp("s2");
        settle();
        check("s2_rsp", rsp_data, 32'hDEAD_BEEF);
        check("s2_rises", 64'(tck_rises - r0), 64'd37);

        // IR 5, tdo high
        r0 = tck_rises;
        issue(2'b01, 6'd5, 32'h0000_0001, 2'd1);
        wait_rsp("s3");
        settle();
        check("s3_rsp", rsp_data, 32'h0000_001F);
        check("s3_rises", 64'(tck_rises - r0), 64'd11);
        check("s3_tms_seq", tms_log[10:0], 11'b11000000110);

        // DR with len 0 -> 1 shift bit
        r0 = tck_rises;
        issue(2'b10, 6'd0, 32'h0000_0001, 2'd1);
        wait_rsp("s4");
        settle();
        check("s4_rsp", rsp_data, 32'h0000_0001);
        check("s4_rises", 64'(tck_rises - r0), 64'd6);

        // DR with len above 32 clamps to 32
        r0 = tck_rises;
        issue(2'b10, 6'd40, 32'hA5A5_0F0F, 2'd2);
        wait_rsp("clamp");
        settle();
        check("clamp_rsp", rsp_data, 32'hA5A5_0F0F);
        check("clamp_rises", 64'(tck_rises - r0), 64'd37);

        // IR 8 with tdo low: upper bits must clear
        issue(2'b01, 6'd8, 32'h0000_003C, 2'd0);
        wait_rsp("ir8");
        settle();
        check("ir8_rsp", rsp_data, 32'h0);

        // Idle clocks with len 0 -> one bit
        r0 = tck_rises;
        issue(2'b11, 6'd0, 32'h0, 2'd1);
        wait_rsp("idle0");
        settle();
        check("idle0_rises", 64'(tck_rises - r0), 64'd1);

        // DR 24 loopback, leaves a nonzero rsp_data for the abort case
        issue(2'b10, 6'd24, 32'h0012_3456, 2'd2);
        wait_rsp("dr24");
        settle();
        check("dr24_rsp", rsp_data, 32'h0012_3456);

        // Reset during DR shift bit 10 (overall TCK bit 13, cycles 53..56)
        issue(2'b10, 6'd32, 32'h1234_5678, 2'd2);
        repeat (53) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        p0 = valid_pulses;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        exp_q.delete();
        idle_tms = 1'b1;
        last_rsp = 32'h0;
        check("abort_tck", jtag_tck, 1'b0);
        check("abort_tms", jtag_tms, 1'b1);
        check("abort_ready", cmd_ready, 1'b1);
        check("abort_rsp", rsp_data, 32'h0);
        repeat (200) @(posedge sys_clk);
        #1;
        check("abort_no_valid", 64'(valid_pulses - p0), 64'd0);

        // Back-to-back idle ops with cmd_valid held high
        r0 = tck_rises;
        p0 = valid_pulses;
        @(negedge sys_clk);
        cmd_op    = 2'b11;
        cmd_len   = 6'd3;
        cmd_data  = 32'h0;
        cmd_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        push_cmd(2'b11, 6'd3, 32'h0, 2'd0);
        cmd_len = 6'd4;
        wait_rsp("b2b_a");
        @(posedge sys_clk);
        #1;
        push_cmd(2'b11, 6'd4, 32'h0, 2'd0);
        cmd_valid = 1'b0;
        wait_rsp("b2b_b");
        settle();
        check("b2b_rises", 64'(tck_rises - r0), 64'd7);
        check("b2b_pulses", 64'(valid_pulses - p0), 64'd2);

        repeat (5) @(posedge sys_clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4, giving sys_clk cycles per TCK half-period (legal range 1..255).
REQ-002 SHALL provide port sys_clk, input, 1 bit: the single clock for all logic.
REQ-003 SHALL provide port sys_rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL provide cmd_valid, input, 1 bit: the command is present.
REQ-005 SHALL provide cmd_ready, output, 1 bit: the engine can accept a command.
REQ-006 SHALL provide cmd_op, input, 2 bits: 00 TAP reset, 01 IR scan, 10 DR scan, 11 idle clocks.
REQ-007 SHALL provide cmd_len, input, 6 bits: shift or idle length, 1..32.
REQ-008 SHALL provide cmd_data, input, 32 bits: TDI bits, shifted LSB first.
REQ-009 SHALL provide rsp_valid, output, 1 bit: single-cycle completion pulse.
REQ-010 SHALL provide rsp_data, output, 32 bits: captured TDO bits, bit i = i-th shifted bit.
REQ-011 SHALL provide jtag_tck, jtag_tms and jtag_tdi, each an output of 1 bit: JTAG drive pins.
REQ-012 SHALL provide jtag_tdo, input, 1 bit: the JTAG target data out.

Function
REQ-013 SHALL accept a command on a sys_clk edge where cmd_valid and cmd_ready are both high, latching op, len and data; cmd_ready SHALL be low from the next cycle until completion.
REQ-014 SHALL treat cmd_len of 0 as 1 and cmd_len above 32 as 32.
REQ-015 SHALL emit each TCK bit as a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles; jtag_tck SHALL idle low.
REQ-016 SHALL update jtag_tms and jtag_tdi only on the first cycle of each low phase.
REQ-017 SHALL sample jtag_tdo on the last sys_clk cycle of each high phase, before the falling edge.
REQ-018 SHALL assume the TAP is in Run-Test/Idle at the start of every command except TAP reset.
REQ-019 TAP reset SHALL produce 6 TCK bits with TMS 1,1,1,1,1,0, ending in Run-Test/Idle.
REQ-020 IR scan SHALL produce a header with TMS 1,1,0,0, then len shift bits, then a trailer with TMS 1,0; the total is len+6 TCK bits.
REQ-021 DR scan SHALL produce a header with TMS 1,0,0, then len shift bits, then a trailer with TMS 1,0; the total is len+5 TCK bits.
REQ-022 During shift bits, TMS SHALL be 0 except on the last shift bit, where it SHALL be 1 (Exit1).
REQ-023 Idle clocks SHALL produce len TCK bits with TMS=0.
REQ-024 jtag_tdi SHALL carry cmd_data[i] on shift bit i and 0 on all non-shift bits.
REQ-025 Only shift-bit samples SHALL be stored in rsp_data; rsp_data bits at or above len SHALL be 0.
REQ-026 For TAP reset and idle ops, rsp_data SHALL be 0.
REQ-027 The state machine SHALL use states IDLE -> HDR -> SHIFT -> TRL -> DONE -> IDLE.
REQ-028 The reset op and the idle op SHALL skip HDR and TRL and use SHIFT as the plain bit sequencer.
REQ-029 A bit counter SHALL count down over the header, shift and trailer lengths.
REQ-030 A phase counter SHALL run 0..CLK_DIV-1.
REQ-031 After the final high phase, one further low-phase period of CLK_DIV cycles SHALL elapse; DONE SHALL then assert rsp_valid for exactly one cycle and cmd_ready in the same cycle.
REQ-032 A command presented in the DONE cycle SHALL be accepted (back-to-back operation), and its first low phase SHALL start on the next cycle.
REQ-033 rsp_data SHALL hold its value until the next rsp_valid.
REQ-034 cmd_* inputs SHALL be ignored while cmd_ready is low.

Reset
REQ-035 On a sys_clk edge with sys_rst high, the block SHALL set jtag_tck=0, jtag_tms=1, jtag_tdi=0, cmd_ready=1, rsp_valid=0, rsp_data=0, all counters to 0 and the state to IDLE.
REQ-036 Reset asserted mid-command SHALL abort the command with no rsp_valid.
REQ-037 The TAP state after reset is unknown; no automatic TAP reset SHALL be issued.

Verification (CLK_DIV=2, 4 sys_clk cycles per TCK bit)
REQ-038 Scenario 1: a TAP reset op -> 6 TCK rising edges with TMS 1,1,1,1,1,0, rsp_valid pulse, rsp_data=0.
REQ-039 Scenario 2: a DR scan, len=32, data 0xDEADBEEF, jtag_tdo looped from jtag_tdi -> 37 TCK bits, rsp_data=0xDEADBEEF.
REQ-040 Scenario 3: an IR scan, len=5, data 0x01, jtag_tdo tied 1 -> TMS 1,1,0,0,0,0,0,0,1,1,0, TDI 1 on the first shift bit only, rsp_data=0x0000001F.
REQ-041 Scenario 4: a DR scan with cmd_len=0, data 0x1, tdo=1 -> 6 TCK bits, rsp_data=0x1.
REQ-042 Scenario 5: sys_rst pulsed during DR shift bit 10 -> next cycle jtag_tck=0, jtag_tms=1, cmd_ready=1, and no rsp_valid ever appears for that command.
REQ-043 Scenario 6: cmd_valid held high across two idle ops (len=3, then len=4) -> the second is accepted in the first's rsp_valid cycle, with exactly 7 TCK bits total and 2 rsp_valid pulses.
